// File: rtl/stage_memory.sv
// stage_memory: vector memory stage; forwards PASS results, serializes STORE lanes to RAM, gathers LOAD lanes from RAM.
module stage_memory #(
  parameter int vectorSize = 4,
  parameter int registerSize = 8,
  parameter int addrWidth = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_in,
  input  logic [1:0]                           MemOp,
  input  logic [addrWidth-1:0]                 base_addr,
  input  logic [vectorSize*registerSize-1:0]   alu_result,
  input  logic [vectorSize*registerSize-1:0]   store_data,
  input  logic [1:0]                           NZ_flags_in,
  output logic                                 stall,
  output logic [addrWidth-1:0]                 mem_addr,
  output logic [registerSize-1:0]              mem_wdata,
  output logic                                 mem_we,
  input  logic [registerSize-1:0]              mem_rdata,
  output logic                                 wb_valid,
  output logic [vectorSize*registerSize-1:0]   wb_data,
  output logic [1:0]                           wb_NZ_flags
);
  localparam int VW = vectorSize * registerSize;
  localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam logic [1:0] IDLE = 2'd0, STORE = 2'd1, LOAD = 2'd2, LAST = 2'd3;
  logic [1:0] state;
  logic [LW-1:0] lane, nl, pl;
  logic [addrWidth-1:0] base_q;
  logic [VW-1:0] sd_q, ld_vec;
  logic [VW-registerSize-1:0] ld_buf;
  logic last_lane;
  assign stall = state != IDLE;
  assign nl = lane + 1'b1;
  assign pl = lane - 1'b1;
  assign last_lane = lane == LW'(vectorSize - 1);
  // the final lane arrives from RAM while in LAST, so it joins the buffered lanes here
  assign ld_vec = {mem_rdata, ld_buf};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lane <= '0;
      base_q <= '0;
      sd_q <= '0;
      ld_buf <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_NZ_flags <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: if (valid_in) begin
          base_q <= base_addr;
          sd_q <= store_data;
          lane <= '0;
          if (MemOp == 2'b10) begin
            state <= STORE;
            mem_we <= 1'b1;
            mem_addr <= base_addr;
            mem_wdata <= store_data[registerSize-1:0];
          end else if (MemOp == 2'b01) begin
            state <= LOAD;
            mem_addr <= base_addr;
          end else begin
            wb_valid <= 1'b1;
            wb_data <= alu_result;
            wb_NZ_flags <= NZ_flags_in;
          end
        end
        STORE: if (last_lane) begin
          state <= IDLE;
          mem_we <= 1'b0;
        end else begin
          lane <= nl;
          mem_addr <= base_q + addrWidth'(nl);
          mem_wdata <= sd_q[nl*registerSize +: registerSize];
        end
        LOAD: begin
          // read data trails the address by one cycle, so it belongs to the previous lane
          if (lane != '0) ld_buf[pl*registerSize +: registerSize] <= mem_rdata;
          if (last_lane) state <= LAST;
          else begin
            lane <= nl;
            mem_addr <= base_q + addrWidth'(nl);
          end
        end
        default: begin
          state <= IDLE;
          wb_valid <= 1'b1;
          wb_data <= ld_vec;
          wb_NZ_flags <= {ld_vec == '0, ld_vec[VW-1]};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: randomized scoreboard bench for stage_memory with a RAM model and a vector-level reference.
module tb_stage_memory;
  logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0;
  logic [1:0] MemOp = '0, NZ_flags_in = '0;
  logic [7:0] base_addr = '0;
  logic [31:0] alu_result = '0, store_data = '0;
  logic stall, mem_we, wb_valid;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [31:0] wb_data;
  logic [1:0] wb_NZ_flags;
  logic [7:0] ram [256] = '{default: 8'h00};
  logic [7:0] ref_ram [256] = '{default: 8'h00};
  logic [33:0] wb_q[$];
  logic [15:0] wr_q[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  stage_memory dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .MemOp(MemOp), .base_addr(base_addr),
    .alu_result(alu_result), .store_data(store_data), .NZ_flags_in(NZ_flags_in),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_NZ_flags(wb_NZ_flags)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (wb_valid) begin
      if (wb_q.size() == 0) chk("unexpected_wb_valid", 1, 0);
      else begin
        logic [33:0] e;
        e = wb_q.pop_front();
        chk("wb_data", wb_data, e[31:0]);
        chk("wb_flags", wb_NZ_flags, e[33:32]);
      end
    end
    if (mem_we) begin
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        logic [15:0] w;
        w = wr_q.pop_front();
        chk("write_addr", mem_addr, w[15:8]);
        chk("write_data", mem_wdata, w[7:0]);
      end
    end
  end

  task automatic model(input logic [1:0] op, input logic [7:0] base, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [1:0] fl, input int nw);
    logic [31:0] v;
    logic [7:0] a;
    if (op == 2'b10) begin
      for (int i = 0; i < nw; i++) begin
        a = base + 8'(i);
        wr_q.push_back({a, sd[i*8 +: 8]});
        ref_ram[a] = sd[i*8 +: 8];
      end
    end else if (op == 2'b01) begin
      for (int i = 0; i < 4; i++) begin
        a = base + 8'(i);
        v[i*8 +: 8] = ref_ram[a];
      end
      wb_q.push_back({v == 32'd0, v[31], v});
    end else wb_q.push_back({fl, alu});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (stall) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] base, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [1:0] fl);
    MemOp = op; base_addr = base; alu_result = alu; store_data = sd; NZ_flags_in = fl;
    valid_in = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] base, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [1:0] fl);
    wait_idle();
    drive(op, base, alu, sd, fl);
    model(op, base, alu, sd, fl, 4);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_flags", wb_NZ_flags, 0);
    reset = 1'b0;
    issue(2'b00, 8'h00, 32'h3232002D, 32'h0, 2'b00);
    chk("pass_stall", stall, 0);
    issue(2'b00, 8'h00, 32'h80000001, 32'h0, 2'b01);
    issue(2'b11, 8'h00, 32'h00000000, 32'h0, 2'b10);
    issue(2'b10, 8'h10, 32'h0, 32'h55AACC33, 2'b00);
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("store_stall_cycles", n, 4);
    issue(2'b01, 8'h10, 32'h0, 32'h0, 2'b00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_valid && n < 20);
    chk("load_latency", n, 6);
    @(posedge clk); #1;
    issue(2'b01, 8'h80, 32'h0, 32'h0, 2'b00);
    issue(2'b10, 8'h20, 32'h0, 32'hFF010203, 2'b00);
    issue(2'b01, 8'h20, 32'h0, 32'h0, 2'b00);
    issue(2'b10, 8'hFE, 32'h0, 32'hA4A3A2A1, 2'b00);
    issue(2'b01, 8'hFE, 32'h0, 32'h0, 2'b00);
    issue(2'b10, 8'h30, 32'h0, 32'h0D0C0B0A, 2'b00);
    @(posedge clk); #1;
    drive(2'b01, 8'h10, 32'h0, 32'h0, 2'b00);
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_idle();
    repeat (8) @(posedge clk);
    #1;
    chk("ignored_load_wbq", wb_q.size(), 0);
    chk("ignored_load_wrq", wr_q.size(), 0);
    wait_idle();
    drive(2'b10, 8'h40, 32'h0, 32'h44332211, 2'b00);
    model(2'b10, 8'h40, 32'h0, 32'h44332211, 2'b00, 2);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ram40", ram[8'h40], 8'h11);
    chk("midrst_ram41", ram[8'h41], 8'h22);
    chk("midrst_ram42", ram[8'h42], 8'h00);
    issue(2'b00, 8'h00, 32'hCAFEF00D, 32'h0, 2'b11);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] sd;
      sd = $urandom;
      if ($urandom_range(0, 3) == 0) sd[31:24] = 8'hFF;
      if ($urandom_range(0, 5) == 0) sd = 32'h0;
      issue(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 15)),
            $urandom, sd, 2'($urandom_range(0, 3)));
    end
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("final_wbq_empty", wb_q.size(), 0);
    chk("final_wrq_empty", wr_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_ram[i]) bad++;
    chk("ram_image_diffs", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
